// File: rtl/freq_meter_pkg.sv
// Shared encodings and limits for the gated edge-counting frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int MIN_GATE_CYCLES = 4;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Brings an asynchronous input into fast_clock and flags its rising edges.
module sync_edge_detect (
  input  logic fast_clock,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      meta_p0 <= async_in;
      // p0 -> p1: metastability settles; p1 -> p2: one-cycle history
      sync_p1 <= meta_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign rise_pulse = sync_p1 & ~hist_p2;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a fixed fast_clock gate window and reports each result.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 16
) (
  input  logic             fast_clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int               TMR_W     = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic [TMR_W-1:0] gate_tmr;
  logic [CNT_W-1:0] edge_acc;
  logic             acc_ovf;
  logic             rise_pulse;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  sync_edge_detect u_sync_edge_detect (
    .fast_clock (fast_clock),
    .rst        (rst),
    .async_in   (sig_in),
    .rise_pulse (rise_pulse)
  );

  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gate_tmr    <= '0;
      edge_acc    <= '0;
      acc_ovf     <= 1'b0;
      freq_count  <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= GATE;
            busy     <= 1'b1;
            gate_tmr <= '0;
            edge_acc <= '0;
            acc_ovf  <= 1'b0;
          end
        end
        GATE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (rise_pulse) begin
              edge_acc <= sat_inc(edge_acc);
              if (edge_acc == CNT_MAX) acc_ovf <= 1'b1;
            end
            if (gate_tmr == LAST_TICK) begin
              state <= REPORT;
              busy  <= 1'b0;
            end else begin
              gate_tmr <= gate_tmr + 1'b1;
            end
          end
        end
        REPORT: begin
          // Edges seen during this cycle are dropped by clearing for the next gate.
          freq_count  <= edge_acc;
          overflow    <= acc_ovf;
          count_valid <= 1'b1;
          gate_tmr    <= '0;
          edge_acc    <= '0;
          acc_ovf     <= 1'b0;
          if (enable) begin
            state <= GATE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed and randomized checks of freq_meter against an edge-counting reference model.
module tb_freq_meter;

  localparam int GC    = 100;
  localparam int CW    = 4;
  localparam int MAXC  = 15;
  localparam int DEPTH = 4096;

  logic          fast_clock;
  logic          rst;
  logic          enable;
  logic          sig_in;
  logic [CW-1:0] freq_count;
  logic          count_valid;
  logic          overflow;
  logic          busy;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;
  int cv_seen = 0;
  bit drv    [0:DEPTH-1];
  bit sig_at [0:DEPTH-1];
  int g      [0:9];

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(CW)) dut (
    .fast_clock  (fast_clock),
    .rst         (rst),
    .enable      (enable),
    .sig_in      (sig_in),
    .freq_count  (freq_count),
    .count_valid (count_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  // sig_in value seen at each rising edge; held low while reset clears the synchronizer
  always @(posedge fast_clock) begin
    sig_at[cyc] <= rst ? sig_in : 1'b0;
    cyc         <= cyc + 1;
  end

  // A rise sampled at edge k is counted when edge k+2 closes a gate cycle.
  function automatic void model(input int gs, output int cnt, output bit ovf);
    int e;
    e = 0;
    for (int k = gs - 1; k <= gs + GC - 2; k++)
      if (sig_at[k] && !sig_at[k-1]) e++;
    cnt = (e > MAXC) ? MAXC : e;
    ovf = (e > MAXC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge fast_clock);
    if (count_valid) cv_seen++;
    sig_in = drv[cyc];
  endtask

  task automatic run_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_high(input int start, input int len);
    for (int i = 0; i < len; i++) drv[start+i] = 1'b1;
  endtask

  task automatic fill_pulses(input int start, input int n, input int high, input int period);
    for (int p = 0; p < n; p++) set_high(start + p*period, high);
  endtask

  task automatic fill_square(input int start, input int len, input int period);
    for (int t = 0; t < len; t++) drv[start+t] = ((t % period) < (period / 2));
  endtask

  task automatic fill_random(input int start, input int len);
    bit v;
    int p;
    v = 1'b0;
    p = $urandom_range(2, 7);
    for (int t = 0; t < len; t++) begin
      if ($urandom_range(0, p - 1) == 0) v = ~v;
      drv[start+t] = v;
    end
  endtask

  task automatic check_report(input int gs, input string tag, output int cnt, output bit ovf);
    run_until(gs + 101);
    chk({tag, " cv early"}, count_valid, 0);
    run_until(gs + 102);
    model(gs, cnt, ovf);
    chk({tag, " cv"}, count_valid, 1);
    chk({tag, " count"}, freq_count, cnt);
    chk({tag, " ovf"}, overflow, ovf);
    run_until(gs + 103);
    chk({tag, " cv drop"}, count_valid, 0);
  endtask

  initial begin
    int  c;
    bit  o;
    int  ga, gb, gc2;

    rst = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    run_until(3);
    chk("rst freq_count", freq_count, 0);
    chk("rst count_valid", count_valid, 0);
    chk("rst overflow", overflow, 0);
    chk("rst busy", busy, 0);

    for (int i = 0; i < 10; i++) g[i] = 3 + 101*i;
    fill_pulses(g[0] + 5, 7, 4, 12);
    fill_square(g[1] + 2, 96, 4);
    fill_pulses(g[2] + 10, 3, 2, 10);
    for (int i = 3; i <= 6; i++) fill_random(g[i], 98);
    set_high(g[7] + 10, 2);
    set_high(g[7] + 30, 2);
    set_high(g[7] + 98, 1);
    set_high(g[8] + 10, 2);
    set_high(g[8] + 30, 2);
    set_high(g[8] + 99, 2);
    fill_pulses(g[9] + 20, 5, 3, 10);

    enable = 1'b1;
    rst = 1'b1;
    run_until(g[0] + 1);
    chk("busy first edge", busy, 1);

    check_report(g[0], "pulses7", c, o);
    chk("pulses7 const count", freq_count, 7);
    chk("pulses7 const ovf", overflow, 0);

    check_report(g[1], "square", c, o);
    chk("square const count", freq_count, 15);
    chk("square const ovf", overflow, 1);

    check_report(g[2], "three", c, o);
    chk("three const count", freq_count, 3);
    chk("three const ovf", overflow, 0);

    for (int i = 3; i <= 6; i++) check_report(g[i], $sformatf("random%0d", i), c, o);

    check_report(g[7], "last gate cycle", c, o);
    chk("last gate cycle const", freq_count, 3);
    check_report(g[8], "report cycle edge", c, o);
    chk("report cycle edge const", freq_count, 2);
    check_report(g[9], "five", c, o);
    chk("five const", freq_count, 5);

    ga = g[0] + 1010;
    run_until(ga + 50);
    chk("abort busy before", busy, 1);
    enable = 1'b0;
    run_until(ga + 51);
    chk("abort busy after", busy, 0);
    cv_seen = 0;
    run_until(ga + 180);
    chk("abort no cv", cv_seen, 0);
    chk("abort hold count", freq_count, 5);
    chk("abort hold ovf", overflow, 0);
    chk("abort idle busy", busy, 0);

    gb = cyc;
    enable = 1'b1;
    fill_square(gb + 1, 300, 6);
    run_until(gb + 40);
    chk("midgate busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst freq_count", freq_count, 0);
    chk("midrst count_valid", count_valid, 0);
    chk("midrst overflow", overflow, 0);
    chk("midrst busy", busy, 0);
    run_until(gb + 45);
    rst = 1'b1;
    gc2 = cyc;
    cv_seen = 0;
    run_until(gc2 + 101);
    chk("post-reset no early cv", cv_seen, 0);
    check_report(gc2, "post-reset", c, o);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
